jk_access_arbiter: RTL and testbench

JK_ACCESS_ARBITER -- requirements
Module: jk_access_arbiter

---
 rtl/jk_access_arbiter.sv | 179 +++++++++++++++++
 tb/tb_jk_access_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_access_arbiter.sv
// jk_access_arbiter
// Round-robin arbiter granting two requesters access to one shared JK
// flip-flop. Each operation drives {j,k} for one cycle, waits SETTLE_CYCLES,
// then samples q and compares it with the JK next state predicted from the
// q value latched at grant time. Mismatches are counted in a saturating counter.
module jk_access_arbiter #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] cmd0,
   input  logic [1:0] cmd1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       j,
   output logic       k,
   input  logic       q,
   output logic       done,
   output logic       done_id,
   output logic       result,
   output logic       err,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Counter load value on entering WAIT; zero means sample on the next edge.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state_reg, state_next;
   logic       ptr_reg, ptr_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       q_prev_reg, q_prev_next;
   logic [1:0] cmd_reg, cmd_next;
   logic       id_reg, id_next;

   logic       gnt0_reg, gnt0_next;
   logic       gnt1_reg, gnt1_next;
   logic       j_reg, j_next;
   logic       k_reg, k_next;
   logic       done_reg, done_next;
   logic       done_id_reg, done_id_next;
   logic       result_reg, result_next;
   logic       err_reg, err_next;
   logic [7:0] err_cnt_reg, err_cnt_next;

   logic       win;
   logic [1:0] win_cmd;
   logic       exp_q;
   logic       mismatch;

   // Winner selection: the pointer breaks ties, a lone requester always wins.
   always_comb begin
      win     = (req0 && req1) ? ptr_reg : req1;
      win_cmd = win ? cmd1 : cmd0;
   end

   // Expected JK next state from the latched command and pre-operation q.
   always_comb begin
      exp_q = q_prev_reg;
      case (cmd_reg)
         2'b00:   exp_q = q_prev_reg;
         2'b01:   exp_q = 1'b0;
         2'b10:   exp_q = 1'b1;
         default: exp_q = ~q_prev_reg;
      endcase
      mismatch = (q != exp_q);
   end

   // Next-state and next-output logic; pulse outputs default low.
   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      cnt_next     = cnt_reg;
      q_prev_next  = q_prev_reg;
      cmd_next     = cmd_reg;
      id_next      = id_reg;
      gnt0_next    = 1'b0;
      gnt1_next    = 1'b0;
      j_next       = 1'b0;
      k_next       = 1'b0;
      done_next    = 1'b0;
      done_id_next = done_id_reg;
      result_next  = result_reg;
      err_next     = err_reg;
      err_cnt_next = err_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               state_next  = DRIVE;
               id_next     = win;
               cmd_next    = win_cmd;
               q_prev_next = q;
               ptr_next    = ~win;
               gnt0_next   = ~win;
               gnt1_next   = win;
               j_next      = win_cmd[1];
               k_next      = win_cmd[0];
            end
         end
         DRIVE: begin
            state_next = WAIT;
            cnt_next   = SETTLE_LOAD;
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next   = IDLE;
               done_next    = 1'b1;
               done_id_next = id_reg;
               result_next  = q;
               err_next     = mismatch;
               if (mismatch && (err_cnt_reg != 8'hFF)) begin
                  err_cnt_next = err_cnt_reg + 8'd1;
               end
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         ptr_reg     <= 1'b0;
         cnt_reg     <= 4'd0;
         q_prev_reg  <= 1'b0;
         cmd_reg     <= 2'b00;
         id_reg      <= 1'b0;
         gnt0_reg    <= 1'b0;
         gnt1_reg    <= 1'b0;
         j_reg       <= 1'b0;
         k_reg       <= 1'b0;
         done_reg    <= 1'b0;
         done_id_reg <= 1'b0;
         result_reg  <= 1'b0;
         err_reg     <= 1'b0;
         err_cnt_reg <= 8'd0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         cnt_reg     <= cnt_next;
         q_prev_reg  <= q_prev_next;
         cmd_reg     <= cmd_next;
         id_reg      <= id_next;
         gnt0_reg    <= gnt0_next;
         gnt1_reg    <= gnt1_next;
         j_reg       <= j_next;
         k_reg       <= k_next;
         done_reg    <= done_next;
         done_id_reg <= done_id_next;
         result_reg  <= result_next;
         err_reg     <= err_next;
         err_cnt_reg <= err_cnt_next;
      end
   end

   assign gnt0    = gnt0_reg;
   assign gnt1    = gnt1_reg;
   assign j       = j_reg;
   assign k       = k_reg;
   assign done    = done_reg;
   assign done_id = done_id_reg;
   assign result  = result_reg;
   assign err     = err_reg;
   assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_jk_access_arbiter.sv
// Bench for jk_access_arbiter: one instance with SETTLE_CYCLES=1 (index 0)
// and one with SETTLE_CYCLES=4 (index 1), each driving its own JK flop model.
// Expected completions are queued at grant time and checked when done fires.
module tb_jk_access_arbiter;

   typedef struct packed {
      logic       r0;
      logic       r1;
      logic [1:0] c0;
      logic [1:0] c1;
      logic       id;
      logic       res;
   } vec_t;

   typedef struct packed {
      logic id;
      logic res;
      logic err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       q_stuck;
   logic       req0_r [2];
   logic       req1_r [2];
   logic [1:0] cmd0_r [2];
   logic [1:0] cmd1_r [2];
   logic       gnt0_w [2];
   logic       gnt1_w [2];
   logic       j_w [2];
   logic       k_w [2];
   logic       done_w [2];
   logic       done_id_w [2];
   logic       result_w [2];
   logic       err_w [2];
   logic [7:0] err_cnt_w [2];
   logic       q_model [2];
   logic       q_dut [2];

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   vec_t tbl [8];

   assign q_dut[0] = q_stuck ? 1'b0 : q_model[0];
   assign q_dut[1] = q_model[1];

   jk_access_arbiter #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst),
      .req0(req0_r[0]), .req1(req1_r[0]), .cmd0(cmd0_r[0]), .cmd1(cmd1_r[0]),
      .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .j(j_w[0]), .k(k_w[0]), .q(q_dut[0]),
      .done(done_w[0]), .done_id(done_id_w[0]), .result(result_w[0]),
      .err(err_w[0]), .err_cnt(err_cnt_w[0])
   );

   jk_access_arbiter #(.SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst),
      .req0(req0_r[1]), .req1(req1_r[1]), .cmd0(cmd0_r[1]), .cmd1(cmd1_r[1]),
      .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .j(j_w[1]), .k(k_w[1]), .q(q_dut[1]),
      .done(done_w[1]), .done_id(done_id_w[1]), .result(result_w[1]),
      .err(err_w[1]), .err_cnt(err_cnt_w[1])
   );

   // Shared JK flip-flop models (cleared by the bench reset for known start).
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (rst) q_model[d] <= 1'b0;
         else begin
            case ({j_w[d], k_w[d]})
               2'b01:   q_model[d] <= 1'b0;
               2'b10:   q_model[d] <= 1'b1;
               2'b11:   q_model[d] <= ~q_model[d];
               default: q_model[d] <= q_model[d];
            endcase
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int d, input logic id, input logic res, input logic e);
      exp_t x;
      x.id = id; x.res = res; x.err = e;
      if (d == 0) sb0.push_back(x);
      else        sb1.push_back(x);
   endtask

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t x;
      logic have;
      for (int d = 0; d < 2; d++) begin
         if (done_w[d] === 1'b1) begin
            have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            if (!have) begin
               n_vec++; n_bad++;
               $display("FAIL unexpected_done dut%0d: done=1, required 0 (cycle %0d)", d, cyc);
            end else begin
               if (d == 0) x = sb0.pop_front();
               else        x = sb1.pop_front();
               check("done_id", int'(done_id_w[d]), int'(x.id));
               check("result", int'(result_w[d]), int'(x.res));
               check("err", int'(err_w[d]), int'(x.err));
               $display("dut%0d done: id=%0d result=%0d err=%0d err_cnt=%0d",
                        d, done_id_w[d], result_w[d], err_w[d], err_cnt_w[d]);
            end
         end
      end
   end

   task automatic wait_grant(input int d, output logic gid, output logic ok);
      ok = 1'b0; gid = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gnt0_w[d] || gnt1_w[d]) begin
            ok = 1'b1; gid = gnt1_w[d];
            break;
         end
      end
      if (!ok) begin
         n_vec++; n_bad++;
         $display("FAIL grant_timeout dut%0d: no grant in 20 cycles, required one", d);
      end else begin
         check("gnt_onehot", int'(gnt0_w[d] & gnt1_w[d]), 0);
      end
   endtask

   task automatic check_reset(input int d);
      check("rst_outputs", int'({gnt0_w[d], gnt1_w[d], j_w[d], k_w[d], done_w[d],
                                 done_id_w[d], result_w[d], err_w[d]}), 0);
      check("rst_err_cnt", int'(err_cnt_w[d]), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req0_r[d] = 1'b0; req1_r[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One complete operation: request, grant, one-cycle drive, timed done.
   task automatic do_op(input int d, input vec_t v, input logic exp_err, input int exp_lat);
      logic       gid, ok;
      logic [1:0] wc;
      int         lat;
      req0_r[d] = v.r0; req1_r[d] = v.r1; cmd0_r[d] = v.c0; cmd1_r[d] = v.c1;
      wait_grant(d, gid, ok);
      req0_r[d] = 1'b0; req1_r[d] = 1'b0;
      if (!ok) return;
      check("grant_id", int'(gid), int'(v.id));
      wc = v.id ? v.c1 : v.c0;
      check("drive_jk", int'({j_w[d], k_w[d]}), int'(wc));
      push_exp(d, v.id, v.res, exp_err);
      @(negedge clk);
      lat = 1;
      check("gnt_pulse", int'({gnt0_w[d], gnt1_w[d], j_w[d], k_w[d]}), 0);
      while (!done_w[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("done_latency", lat, exp_lat);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t v;
      logic gid, ok, saw_early;
      int   last, gcyc, dcyc;

      // {r0, r1, c0, c1, expected id, expected result}; q starts at 0, pointer 0
      tbl[0] = '{1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1}; // set
      tbl[1] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1}; // lone req0 wins despite pointer=1
      tbl[2] = '{1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0}; // reset
      tbl[3] = '{1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1}; // tie, pointer 0, toggle
      tbl[4] = '{1'b1, 1'b1, 2'b01, 2'b11, 1'b1, 1'b0}; // tie, pointer 1, toggle
      tbl[5] = '{1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1}; // lone req1 wins despite pointer=0
      tbl[6] = '{1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1}; // tie, pointer 0, hold
      tbl[7] = '{1'b0, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0}; // toggle

      rst = 1'b1; q_stuck = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req0_r[d] = 1'b0; req1_r[d] = 1'b0; cmd0_r[d] = 2'b00; cmd1_r[d] = 2'b00;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset(0);
      check_reset(1);

      // Table-driven single operations on the SETTLE_CYCLES=1 instance
      for (int i = 0; i < 8; i++) begin
         do_op(0, tbl[i], 1'b0, 2);
      end

      // Both requesters held with toggle commands: alternating grants, period 3
      do_reset();
      req0_r[0] = 1'b1; req1_r[0] = 1'b1; cmd0_r[0] = 2'b11; cmd1_r[0] = 2'b11;
      last = 0;
      for (int i = 0; i < 4; i++) begin
         wait_grant(0, gid, ok);
         if (!ok) break;
         check("alt_grant_id", int'(gid), i % 2);
         if (i > 0) check("alt_period", cyc - last, 3);
         last = cyc;
         push_exp(0, gid, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      end
      req0_r[0] = 1'b0; req1_r[0] = 1'b0;
      repeat (6) @(negedge clk);
      check("alt_drain", sb0.size(), 0);

      // Faulty q stuck at 0 under set commands: err every time, counter saturates
      do_reset();
      q_stuck = 1'b1;
      v = '{1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
      for (int i = 1; i <= 300; i++) begin
         do_op(0, v, 1'b1, 2);
         check("err_cnt", int'(err_cnt_w[0]), (i < 255) ? i : 255);
      end
      q_stuck = 1'b0;

      // Reset during WAIT: abort with no done, pointer back to 0
      req0_r[0] = 1'b1; cmd0_r[0] = 2'b10;
      wait_grant(0, gid, ok);
      req0_r[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset(0);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("abort_no_done", int'(done_w[0]), 0);
      end
      v = '{1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b1};
      do_op(0, v, 1'b0, 2);
      check("post_abort_err_cnt", int'(err_cnt_w[0]), 0);

      // SETTLE_CYCLES=4: done five cycles after grant, late request waits for IDLE
      v = '{1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1};
      do_op(1, v, 1'b0, 5);
      req0_r[1] = 1'b1; cmd0_r[1] = 2'b01;
      wait_grant(1, gid, ok);
      req0_r[1] = 1'b0;
      check("s4_grant_id", int'(gid), 0);
      check("s4_drive_jk", int'({j_w[1], k_w[1]}), 1);
      push_exp(1, 1'b0, 1'b0, 1'b0);
      gcyc = cyc;
      repeat (2) @(negedge clk);
      req1_r[1] = 1'b1; cmd1_r[1] = 2'b11;
      saw_early = 1'b0; dcyc = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gnt1_w[1]) saw_early = 1'b1;
         if (done_w[1]) begin
            dcyc = cyc;
            break;
         end
      end
      check("s4_done_latency", dcyc - gcyc, 5);
      check("s4_no_early_grant", int'(saw_early), 0);
      wait_grant(1, gid, ok);
      req1_r[1] = 1'b0;
      check("s4_late_grant_id", int'(gid), 1);
      check("s4_grant_after_idle", cyc - dcyc, 1);
      push_exp(1, 1'b1, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      check("final_drain", sb0.size() + sb1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
